// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between the
// instruction-fetch (IF) and load/store (D) requesters of a CPU.
//   clk, reset             : clock, synchronous active-high reset
//   if_req/if_addr         : fetch request, held until if_gnt
//   if_gnt                 : fetch accepted this cycle (combinational)
//   if_rvalid/if_rdata     : fetch response, one cycle after grant
//   d_req/d_we/d_addr/d_wdata : load/store request, held until d_gnt
//   d_gnt                  : data request accepted this cycle (combinational)
//   d_rvalid/d_rdata       : load response, one cycle after grant
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : memory port
//   cpu_stall              : some request is pending but not granted
module mem_port_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          cpu_stall
);

  localparam int unsigned CW       = 4;
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] WAIT_LIM = CW'(MAX_WAIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  owner_t        resp_owner;
  logic [CW-1:0] wait_cnt;
  logic          if_win;
  logic          d_win;

  // Data wins conflicts unless fetch has been denied MAX_WAIT times in a row
  always_comb begin
    if_win = 1'b0;
    d_win  = 1'b0;
    if (!reset) begin
      if_win = if_req && (!d_req || (wait_cnt >= WAIT_LIM));
      d_win  = d_req && !if_win;
    end
  end

  assign if_gnt    = if_win;
  assign d_gnt     = d_win;
  assign cpu_stall = !reset && ((if_req && !if_win) || (d_req && !d_win));

  // Memory port follows the winner; idle and reset drive zeros
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_win) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
    end else if (d_win) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  // Response owner tag is taken from the grant; stores return nothing
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_owner <= OWN_NONE;
      wait_cnt   <= '0;
    end else begin
      if (if_win)                resp_owner <= OWN_IF;
      else if (d_win && !d_we)   resp_owner <= OWN_D;
      else                       resp_owner <= OWN_NONE;

      if (if_win || !if_req)                 wait_cnt <= '0;
      else if (d_win && wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + CW'(1);
    end
  end

  assign if_rvalid = (resp_owner == OWN_IF);
  assign d_rvalid  = (resp_owner == OWN_D);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid  ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int unsigned AW       = 32;
  localparam int unsigned DW       = 32;
  localparam int unsigned MAX_WAIT = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          cpu_stall;
  logic          init_mem;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .cpu_stall(cpu_stall)
  );

  function automatic logic [31:0] word_init(input int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  // Single-port synchronous memory seen by the arbiter
  logic [31:0] tmem [256];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) tmem[i] <= word_init(i);
    end else if (mem_en) begin
      if (mem_we) tmem[mem_addr[9:2]] <= mem_wdata;
      else        mem_rdata <= tmem[mem_addr[9:2]];
    end
  end

  // Reference model state
  logic [31:0] refmem [256];
  int          pend;       // 0 none, 1 fetch response due, 2 load response due
  logic [31:0] pdata;
  int          denied;     // consecutive cycles IF asked and D was granted
  logic        last_if_gnt, last_d_gnt;
  logic        prev_ir, prev_ig, prev_dr, prev_dg, prev_dwe;
  logic [31:0] prev_ia, prev_da, prev_dwd;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic ir, input logic [31:0] ia,
                      input logic dr, input logic dwe, input logic [31:0] da,
                      input logic [31:0] dwd);
    logic eig, edg;
    logic [31:0] eaddr, ewd;
    reset = rst; if_req = ir; if_addr = ia;
    d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
    #1;
    eig = !rst && ir && (!dr || denied >= int'(MAX_WAIT));
    edg = !rst && dr && !eig;
    chk("if_gnt", 64'(if_gnt), 64'(eig));
    chk("d_gnt", 64'(d_gnt), 64'(edg));
    chk("mem_en", 64'(mem_en), 64'(eig || edg));
    chk("mem_we", 64'(mem_we), 64'(edg && dwe));
    if (rst || eig || edg) begin
      eaddr = eig ? ia : (edg ? da : 32'd0);
      ewd   = edg ? dwd : 32'd0;
      chk("mem_addr", 64'(mem_addr), 64'(eaddr));
      chk("mem_wdata", 64'(mem_wdata), 64'(ewd));
    end
    chk("cpu_stall", 64'(cpu_stall), 64'(!rst && ((ir && !eig) || (dr && !edg))));
    chk("if_rvalid", 64'(if_rvalid), 64'(pend == 1));
    chk("if_rdata", 64'(if_rdata), 64'((pend == 1) ? pdata : 32'd0));
    chk("d_rvalid", 64'(d_rvalid), 64'(pend == 2));
    chk("d_rdata", 64'(d_rdata), 64'((pend == 2) ? pdata : 32'd0));
    chk("wait_cnt", 64'(dut.wait_cnt), 64'(denied));
    if (prev_ir && !prev_ig) chk("if_hold", {31'd0, ir, ia}, {31'd0, 1'b1, prev_ia});
    if (prev_dr && !prev_dg) chk("d_hold", {ir & 1'b0, dr, dwe, da, dwd[29:0]},
                                           {1'b0, 1'b1, prev_dwe, prev_da, prev_dwd[29:0]});
    prev_ir = ir; prev_ig = eig; prev_ia = ia;
    prev_dr = dr; prev_dg = edg; prev_da = da; prev_dwe = dwe; prev_dwd = dwd;
    @(posedge clk);
    if (rst) begin
      pend = 0; denied = 0;
    end else begin
      if (eig) begin
        pend = 1; pdata = refmem[ia[9:2]];
      end else if (edg && !dwe) begin
        pend = 2; pdata = refmem[da[9:2]];
      end else pend = 0;
      if (edg && dwe) refmem[da[9:2]] = dwd;
      if (eig || !ir) denied = 0;
      else if (edg && denied < 15) denied++;
    end
    last_if_gnt = eig; last_d_gnt = edg;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic        ip, dp, dwe_r;
    logic [31:0] ia_r, da_r, dwd_r;
    logic [5:0]  seq;
    reset = 1'b1; init_mem = 1'b1;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    pend = 0; pdata = 0; denied = 0;
    prev_ir = 0; prev_ig = 0; prev_dr = 0; prev_dg = 0; prev_dwe = 0;
    prev_ia = 0; prev_da = 0; prev_dwd = 0;
    for (int i = 0; i < 256; i++) refmem[i] = word_init(i);
    @(posedge clk);
    @(negedge clk);
    init_mem = 1'b0;

    // Reset held, then released idle
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);

    // Fetch-only stream
    step(0, 1, 32'h00, 0, 0, 0, 0);
    step(0, 1, 32'h04, 0, 0, 0, 0);
    step(0, 1, 32'h08, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Conflict: load wins, fetch follows
    step(0, 1, 32'h10, 1, 0, 32'h100, 0);
    step(0, 1, 32'h10, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Store then load the same word
    step(0, 0, 0, 1, 1, 32'h40, 32'hDEADBEEF);
    step(0, 0, 0, 1, 0, 32'h40, 0);
    chk("st_ld_data", 64'(d_rdata), 64'(32'hDEADBEEF));
    step(0, 0, 0, 0, 0, 0, 0);

    // Starvation: D held, IF wins the 4th conflict
    seq = '0;
    for (int k = 0; k < 6; k++) begin
      step(0, k < 4, 32'h80, 1, 0, 32'h200, 0);
      seq[k] = last_if_gnt;
    end
    chk("starve_seq", 64'(seq), 64'(6'b001000));
    chk("starve_cnt_clr", 64'(dut.wait_cnt), 64'(0));
    step(0, 0, 0, 0, 0, 0, 0);

    // Reset pulsed right after a fetch grant
    step(0, 1, 32'h20, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rst_drop_rvalid", 64'(if_rvalid), 64'(0));
    step(0, 1, 32'h00, 0, 0, 0, 0);
    step(0, 1, 32'h04, 0, 0, 0, 0);
    step(0, 1, 32'h08, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic from protocol-respecting requesters
    ip = 0; dp = 0; dwe_r = 0; ia_r = 0; da_r = 0; dwd_r = 0;
    for (int c = 0; c < 400; c++) begin
      if (!ip && ($urandom % 2 == 0)) begin
        ip = 1; ia_r = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      end
      if (!dp && ($urandom % 3 != 0)) begin
        dp = 1; dwe_r = ($urandom % 3 == 0);
        da_r = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        dwd_r = $urandom;
      end
      step(($urandom % 64) == 0, ip, ia_r, dp, dwe_r, da_r, dwd_r);
      if (last_if_gnt) ip = 0;
      if (last_d_gnt)  dp = 0;
    end
    step(0, 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between the CPU's instruction-fetch requester (IF) and its load/store requester (D).
- Sits between the CPU datapath and the unified memory. Grants one request per cycle and routes the 1-cycle-latency read data back to its owner.
- Raises a stall to the CPU whenever a request is waiting.
- Data accesses have priority. A wait counter prevents fetch starvation.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- MAX_WAIT, 3, number of consecutive denied IF cycles after which IF wins the next conflict. Legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- if_req  input  1  fetch request; held with if_addr until granted
- if_addr  input  AW  fetch address
- if_gnt  output  1  fetch accepted this cycle (combinational)
- if_rvalid  output  1  if_rdata valid (registered)
- if_rdata  output  DW  fetch data
- d_req  input  1  load/store request; held with d_we, d_addr, d_wdata until granted
- d_we  input  1  1 = store, 0 = load
- d_addr  input  AW  data address
- d_wdata  input  DW  store data
- d_gnt  output  1  data request accepted this cycle (combinational)
- d_rvalid  output  1  d_rdata valid for loads (registered)
- d_rdata  output  DW  load data
- mem_en  output  1  memory access strobe
- mem_we  output  1  memory write enable
- mem_addr  output  AW  memory address
- mem_wdata  output  DW  memory write data
- mem_rdata  input  DW  memory read data, valid the cycle after a read with mem_en=1, mem_we=0
- cpu_stall  output  1  a request is pending but not granted this cycle

Behaviour:
- Reset (synchronous, active-high, clk edge):
  - resp_owner <= NONE; wait_cnt <= 0.
  - if_rvalid = d_rvalid = 0 in the cycle after the reset edge.
  - While reset is high: if_gnt = d_gnt = mem_en = mem_we = cpu_stall = 0; mem_addr, mem_wdata driven 0.
  - if_rdata/d_rdata read 0 whenever their rvalid is 0.
- Arbitration, combinational each cycle:
  - Only D requests: grant D.
  - Only IF requests: grant IF.
  - Both request: grant IF if wait_cnt >= MAX_WAIT, otherwise grant D.
  - Exactly one grant per cycle, never both.
- Memory drive on a grant:
  - mem_en = 1.
  - mem_addr is the winner's address.
  - mem_we = d_we if D wins, 0 if IF wins.
  - mem_wdata = d_wdata if D wins, otherwise 0.
- No grant: mem_en = 0, mem_we = 0.
- cpu_stall = (if_req & ~if_gnt) | (d_req & ~d_gnt).
- Response FSM (resp_owner: NONE, IF, D), updated each edge:
  - IF granted -> IF.
  - D granted with d_we=0 -> D.
  - Otherwise (store or no grant) -> NONE.
- Response outputs:
  - if_rvalid = (resp_owner==IF); if_rdata = mem_rdata when valid.
  - d_rvalid = (resp_owner==D); d_rdata = mem_rdata when valid.
- Read latency: exactly 1 cycle from grant to rvalid. Back-to-back grants are allowed every cycle, so throughput is 1 access per cycle.
- Stores produce no rvalid. The write commits at the grant edge.
- Starvation counter wait_cnt (4 bits):
  - Clears to 0 when IF is granted or if_req=0.
  - Increments when if_req=1 and D is granted.
  - Saturates at 15.
- Request stability: a requester changing address or data while req=1 and not granted is a protocol violation. The block does not check for it. The bench asserts it never happens.
- Reset asserted mid-operation: any pending response is discarded. No rvalid is issued after the reset edge, and wait_cnt clears.
- Simultaneous events:
  - Read granted in cycle N and another access granted in cycle N+1: the N response appears in N+1 and the N+1 response in N+2. No overlap or loss.
  - The owner tag is captured from the grant, never from the current req.

Test Plan:
- Reset held 2 cycles, then released with no requests -> mem_en=0, all gnt/rvalid=0, cpu_stall=0 throughout.
- IF only, if_addr=0x00,0x04,0x08 on consecutive cycles -> if_gnt=1 each cycle; if_rvalid in cycles 2..4 with if_rdata = memory contents of 0x00, 0x04, 0x08; cpu_stall=0.
- Conflict: if_req with addr 0x10 and d_req load with addr 0x100 in the same cycle -> d_gnt=1, if_gnt=0, cpu_stall=1; next cycle if_gnt=1, d_rvalid=1 with data at 0x100; following cycle if_rvalid=1 with data at 0x10.
- Store 0xDEADBEEF to 0x40, then load 0x40 -> store grant: mem_we=1, no d_rvalid; load grant next cycle; d_rdata=0xDEADBEEF one cycle after the load grant.
- Starvation, MAX_WAIT=3, d_req held continuously with if_req=1 -> D granted for 3 cycles, IF granted on the 4th, then D resumes; wait_cnt back to 0 after the IF grant.
- Reset pulsed in the cycle after an IF read grant -> if_rvalid stays 0 after the reset edge; wait_cnt=0; a fresh request after release behaves exactly as in the second scenario.
